// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - shared constants, sidecar entry type and input clamp helper
//
// Purpose: common definitions for the escape-time issue/recirculation scheduler.
//   FRAC_BITS_DEF : default fractional bits of the signed 32-bit fixed-point format (Q4.28)
//   FX_TWO        : 2.0 in Q4.28, the per-component escape / clamp bound
//   FX_FOUR_SQ    : 4.0 in Q4.28 widened to 33 bits, the squared-magnitude bound
//   sc_entry_t    : one sidecar slot {valid, id, iter, z_re, z_im}
//   fx_clamp      : saturates a signed component to +/- a limit
package mandel_pkg;

  localparam int FRAC_BITS_DEF = 28;
  localparam int SC_ID_W       = 16;
  localparam int SC_ITER_W     = 16;

  localparam logic [31:0] FX_TWO     = 32'h2000_0000;
  localparam logic [32:0] FX_FOUR_SQ = 33'h0_4000_0000;

  typedef struct packed {
    logic                 valid;
    logic [SC_ID_W-1:0]   id;
    logic [SC_ITER_W-1:0] iter;
    logic [31:0]          z_re;
    logic [31:0]          z_im;
  } sc_entry_t;

  function automatic logic [31:0] fx_clamp(input logic [31:0] v, input logic [31:0] lim);
    logic [31:0] neg_lim;
    logic [31:0] res;
    neg_lim = 32'd0 - lim;
    if ($signed(v) > $signed(lim)) begin
      res = lim;
    end else if ($signed(v) < $signed(neg_lim)) begin
      res = neg_lim;
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/mandel_escape_check.sv
// rtl/mandel_escape_check.sv - combinational escape / iteration-limit decision for a returning point
//
// Purpose: decides whether the point in the return slot leaves the pipeline.
// Ports:
//   z_re, z_im  in  32      current z of the returning point (Q4.28)
//   aa, bb      in  32      z_re^2 and z_im^2 from the multiplier (Q4.28)
//   iter        in  ITER_W  iterations already counted for this point
//   max_iter    in  ITER_W  iteration limit
//   retire      out 1       point leaves the pipeline (escaped or limit reached)
//   escaped     out 1       point escaped
module mandel_escape_check
  import mandel_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ITER_W    = SC_ITER_W
) (
  input  logic [31:0]       z_re,
  input  logic [31:0]       z_im,
  input  logic [31:0]       aa,
  input  logic [31:0]       bb,
  input  logic [ITER_W-1:0] iter,
  input  logic [ITER_W-1:0] max_iter,
  output logic              retire,
  output logic              escaped
);

  localparam logic [31:0] TWO     = (FRAC_BITS == FRAC_BITS_DEF) ? FX_TWO
                                                                 : (32'd1 << (FRAC_BITS + 1));
  localparam logic [31:0] NEG_TWO = 32'd0 - TWO;
  localparam logic [32:0] FOUR_SQ = (FRAC_BITS == FRAC_BITS_DEF) ? FX_FOUR_SQ
                                                                 : (33'd1 << (FRAC_BITS + 2));

  logic        big_re;
  logic        big_im;
  logic        big_sum;
  logic [32:0] sq_sum;

  // The squared sum is only meaningful when both components are within +/-2.0;
  // outside that range the per-component tests already force escape, so the
  // (possibly wrapped) squares are harmlessly ORed in.
  always_comb begin
    big_re  = ($signed(z_re) > $signed(TWO)) || ($signed(z_re) < $signed(NEG_TWO));
    big_im  = ($signed(z_im) > $signed(TWO)) || ($signed(z_im) < $signed(NEG_TWO));
    sq_sum  = {1'b0, aa} + {1'b0, bb};
    big_sum = sq_sum > FOUR_SQ;
    escaped = big_re | big_im | big_sum;
    retire  = escaped | (iter >= max_iter);
  end

endmodule

// File: rtl/mandel_iter_sched.sv
// rtl/mandel_iter_sched.sv - issue/recirculation scheduler for the pipelined escape-time datapath
//
// Purpose: accepts points c, drives the external squaring multiplier, forms
// z' = z^2 + c on return and recirculates each point until it escapes or hits
// max_iter, then retires {id, iter, escaped} on a valid/ready output.
// Optional build macro: MANDEL_STATS_EN adds stat_accepted/stat_retired/stat_stall.
// Ports:
//   aclk, reset                    clock, synchronous active-high reset
//   in_valid/in_ready              point handshake; in_cr/in_ci (Q4.28), in_id
//   max_iter                       iteration limit, sampled at each return
//   out_valid/out_ready            result handshake; out_id, out_iter, out_escaped
//   busy                           any point in flight or a result held
//   mul_ld                         multiplier clear (follows reset)
//   mul_a/mul_b/mul_a0/mul_b0      z and c issued to the multiplier
//   mul_aa/mul_bb/mul_ab           squares / cross product returned after MUL_LAT cycles
//   mul_a0r/mul_b0r                c returned alongside
//   stat_*                         (MANDEL_STATS_EN only) accepted, retired, blocked-retire cycles
module mandel_iter_sched
  import mandel_pkg::*;
#(
  parameter int MUL_LAT   = 1,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ID_W      = SC_ID_W,
  parameter int ITER_W    = SC_ITER_W
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_cr,
  input  logic [31:0]       in_ci,
  input  logic [ID_W-1:0]   in_id,
  input  logic [ITER_W-1:0] max_iter,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_escaped,
  output logic              busy,
  output logic              mul_ld,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  output logic [31:0]       mul_a0,
  output logic [31:0]       mul_b0,
  input  logic [31:0]       mul_aa,
  input  logic [31:0]       mul_bb,
  input  logic [31:0]       mul_ab,
  input  logic [31:0]       mul_a0r,
  input  logic [31:0]       mul_b0r
`ifdef MANDEL_STATS_EN
  ,
  output logic [31:0]       stat_accepted,
  output logic [31:0]       stat_retired,
  output logic [31:0]       stat_stall
`endif
);

  // sc[0] is loaded with the issued slot on the same edge the multiplier
  // captures mul_a/mul_b; sc[MUL_LAT-1] therefore lines up with mul_aa etc.
  sc_entry_t   sc [MUL_LAT];
  sc_entry_t   ret;
  sc_entry_t   issue;
  logic [31:0] issue_c_re;
  logic [31:0] issue_c_im;

  logic chk_retire;
  logic chk_escaped;
  logic retire_req;
  logic out_free;
  logic retire_go;
  logic retire_blocked;

  assign ret    = sc[MUL_LAT-1];
  assign mul_ld = reset;

  mandel_escape_check #(
    .FRAC_BITS (FRAC_BITS),
    .ITER_W    (ITER_W)
  ) u_escape_check (
    .z_re     (ret.z_re),
    .z_im     (ret.z_im),
    .aa       (mul_aa),
    .bb       (mul_bb),
    .iter     (ret.iter),
    .max_iter (max_iter),
    .retire   (chk_retire),
    .escaped  (chk_escaped)
  );

  always_comb begin
    retire_req     = ret.valid & chk_retire;
    out_free       = ~out_valid | out_ready;
    retire_go      = retire_req & out_free;
    retire_blocked = retire_req & ~out_free;
    in_ready       = ~ret.valid | retire_go;

    issue      = '0;
    issue_c_re = '0;
    issue_c_im = '0;
    if (reset) begin
      // issue nothing; multiplier inputs read as zero during reset
    end else if (ret.valid & ~retire_go) begin
      issue.valid = 1'b1;
      issue.id    = ret.id;
      issue_c_re  = mul_a0r;
      issue_c_im  = mul_b0r;
      if (retire_blocked) begin
        // Output full: send z_k round again unchanged; it is retried next pass.
        issue.iter = ret.iter;
        issue.z_re = ret.z_re;
        issue.z_im = ret.z_im;
      end else begin
        issue.iter = ret.iter + 1'b1;
        issue.z_re = mul_aa - mul_bb + mul_a0r;
        issue.z_im = {mul_ab[30:0], 1'b0} + mul_b0r;
      end
    end else if (in_valid) begin
      // in_ready is necessarily high on this path
      issue.valid = 1'b1;
      issue.id    = in_id;
      issue_c_re  = fx_clamp(in_cr, FX_TWO);
      issue_c_im  = fx_clamp(in_ci, FX_TWO);
    end

    mul_a  = issue.z_re;
    mul_b  = issue.z_im;
    mul_a0 = issue_c_re;
    mul_b0 = issue_c_im;
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        sc[i] <= '0;
      end
      out_valid   <= 1'b0;
      out_id      <= '0;
      out_iter    <= '0;
      out_escaped <= 1'b0;
    end else begin
      sc[0] <= issue;
      for (int i = 1; i < MUL_LAT; i++) begin
        sc[i] <= sc[i-1];
      end
      if (retire_go) begin
        out_valid   <= 1'b1;
        out_id      <= ret.id;
        out_iter    <= ret.iter;
        out_escaped <= chk_escaped;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    busy = out_valid;
    for (int i = 0; i < MUL_LAT; i++) begin
      busy = busy | sc[i].valid;
    end
  end

`ifdef MANDEL_STATS_EN
  logic accept;
  assign accept = in_valid & in_ready;

  always_ff @(posedge aclk) begin
    if (reset) begin
      stat_accepted <= '0;
      stat_retired  <= '0;
      stat_stall    <= '0;
    end else begin
      if (accept) begin
        stat_accepted <= stat_accepted + 32'd1;
      end
      if (retire_go) begin
        stat_retired <= stat_retired + 32'd1;
      end
      if (retire_blocked) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mandel_iter_sched.sv
// tb/tb_mandel_iter_sched.sv - self-checking bench for mandel_iter_sched with a behavioural multiplier
//
// Purpose: drives directed points from a vector table, plus burst, output-stall
// and mid-run reset sequences, against a MUL_LAT=4 instance.
// Optional build macro: MANDEL_STATS_EN connects and checks the stat counters.
module tb_mandel_iter_sched;

  localparam int LAT = 4;

  logic        aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_cr;
  logic [31:0] in_ci;
  logic [15:0] in_id;
  logic [15:0] max_iter;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_id;
  logic [15:0] out_iter;
  logic        out_escaped;
  logic        busy;
  logic        mul_ld;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_a0;
  logic [31:0] mul_b0;
  logic [31:0] mul_aa;
  logic [31:0] mul_bb;
  logic [31:0] mul_ab;
  logic [31:0] mul_a0r;
  logic [31:0] mul_b0r;
`ifdef MANDEL_STATS_EN
  logic [31:0] stat_accepted;
  logic [31:0] stat_retired;
  logic [31:0] stat_stall;
`endif

  mandel_iter_sched #(
    .MUL_LAT   (LAT),
    .FRAC_BITS (28),
    .ID_W      (16),
    .ITER_W    (16)
  ) dut (
    .aclk        (aclk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cr       (in_cr),
    .in_ci       (in_ci),
    .in_id       (in_id),
    .max_iter    (max_iter),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_id      (out_id),
    .out_iter    (out_iter),
    .out_escaped (out_escaped),
    .busy        (busy),
    .mul_ld      (mul_ld),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_a0      (mul_a0),
    .mul_b0      (mul_b0),
    .mul_aa      (mul_aa),
    .mul_bb      (mul_bb),
    .mul_ab      (mul_ab),
    .mul_a0r     (mul_a0r),
    .mul_b0r     (mul_b0r)
`ifdef MANDEL_STATS_EN
    ,
    .stat_accepted (stat_accepted),
    .stat_retired  (stat_retired),
    .stat_stall    (stat_stall)
`endif
  );

  // Behavioural Q4.28 multiplier, LAT register stages, cleared by mul_ld.
  function automatic logic [31:0] fx_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> 28;
    return p[31:0];
  endfunction

  logic [31:0] p_aa [LAT];
  logic [31:0] p_bb [LAT];
  logic [31:0] p_ab [LAT];
  logic [31:0] p_a0 [LAT];
  logic [31:0] p_b0 [LAT];

  always @(posedge aclk) begin
    if (mul_ld) begin
      for (int i = 0; i < LAT; i++) begin
        p_aa[i] <= '0;
        p_bb[i] <= '0;
        p_ab[i] <= '0;
        p_a0[i] <= '0;
        p_b0[i] <= '0;
      end
    end else begin
      p_aa[0] <= fx_mul(mul_a, mul_a);
      p_bb[0] <= fx_mul(mul_b, mul_b);
      p_ab[0] <= fx_mul(mul_a, mul_b);
      p_a0[0] <= mul_a0;
      p_b0[0] <= mul_b0;
      for (int i = 1; i < LAT; i++) begin
        p_aa[i] <= p_aa[i-1];
        p_bb[i] <= p_bb[i-1];
        p_ab[i] <= p_ab[i-1];
        p_a0[i] <= p_a0[i-1];
        p_b0[i] <= p_b0[i-1];
      end
    end
  end

  assign mul_aa  = p_aa[LAT-1];
  assign mul_bb  = p_bb[LAT-1];
  assign mul_ab  = p_ab[LAT-1];
  assign mul_a0r = p_a0[LAT-1];
  assign mul_b0r = p_b0[LAT-1];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; holds the point until in_ready lets it in.
  task automatic send_point(input logic [31:0] cr, input logic [31:0] ci, input logic [15:0] id);
    int n;
    n = 0;
    in_cr    = cr;
    in_ci    = ci;
    in_id    = id;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, id %0d", n, id);
    end
    @(negedge aclk);
    in_valid = 1'b0;
  endtask

  // Waits for out_valid and captures the result; caller sets out_ready.
  task automatic wait_result(output logic [15:0] rid, output logic [15:0] riter, output logic resc);
    int n;
    n     = 0;
    rid   = '0;
    riter = '0;
    resc  = 1'b0;
    while (!out_valid && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL result_timeout: out_valid low for %0d cycles", n);
    end else begin
      rid   = out_id;
      riter = out_iter;
      resc  = out_escaped;
      @(negedge aclk);
    end
  endtask

  typedef struct {
    logic [31:0] cr;
    logic [31:0] ci;
    logic [15:0] mi;
    logic [15:0] iter;
    logic        esc;
  } vec_t;

  vec_t vecs [15];

  typedef struct {
    logic [31:0] cr;
    logic [15:0] id;
    logic [15:0] iter;
    logic        esc;
  } burst_t;

  burst_t burst_in [4];
  burst_t burst_out [4];

  logic [15:0] rid;
  logic [15:0] riter;
  logic        resc;
  logic        flag;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_cr     = '0;
    in_ci     = '0;
    in_id     = '0;
    max_iter  = 16'd100;
    out_ready = 1'b1;

    //           cr             ci             max_iter iter    esc
    vecs[0]  = '{32'h2000_0000, 32'h0000_0000, 16'd100, 16'd2,  1'b1}; // z 0,2,6
    vecs[1]  = '{32'h1000_0000, 32'h0000_0000, 16'd100, 16'd3,  1'b1}; // z 0,1,2,5
    vecs[2]  = '{32'h0000_0000, 32'h0000_0000, 16'd50,  16'd50, 1'b0};
    vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 16'd0,   16'd0,  1'b0}; // max_iter 0
    vecs[4]  = '{32'h7000_0000, 32'h0000_0000, 16'd100, 16'd2,  1'b1}; // clamps to 2.0
    vecs[5]  = '{32'h0000_0000, 32'h2000_0000, 16'd100, 16'd2,  1'b1}; // z2 = -4+2i
    vecs[6]  = '{32'hE000_0000, 32'h0000_0000, 16'd10,  16'd10, 1'b0}; // -2 sticks at 2
    vecs[7]  = '{32'hF000_0000, 32'h0000_0000, 16'd20,  16'd20, 1'b0}; // 0,-1 cycle
    vecs[8]  = '{32'h0800_0000, 32'h0000_0000, 16'd100, 16'd5,  1'b1}; // .5,.75,1.0625,1.63,3.15
    vecs[9]  = '{32'h0000_0000, 32'h9000_0000, 16'd100, 16'd2,  1'b1}; // ci clamps to -2
    vecs[10] = '{32'h8000_0000, 32'h0000_0000, 16'd7,   16'd7,  1'b0}; // clamps to -2
    vecs[11] = '{32'h1000_0000, 32'h0000_0000, 16'd2,   16'd2,  1'b0}; // limit at z=2
    vecs[12] = '{32'h1000_0000, 32'h0000_0000, 16'd3,   16'd3,  1'b1}; // escape beats limit
    vecs[13] = '{32'h1800_0000, 32'h1800_0000, 16'd100, 16'd1,  1'b1}; // square sum 4.5
    vecs[14] = '{32'h2000_0000, 32'h2000_0000, 16'd100, 16'd1,  1'b1}; // square sum 8

    burst_in[0]  = '{32'h2000_0000, 16'd1, 16'd0, 1'b0};
    burst_in[1]  = '{32'h0000_0000, 16'd2, 16'd0, 1'b0};
    burst_in[2]  = '{32'h1000_0000, 16'd3, 16'd0, 1'b0};
    burst_in[3]  = '{32'hE000_0000, 16'd4, 16'd0, 1'b0};
    burst_out[0] = '{32'h0, 16'd1, 16'd2,  1'b1};
    burst_out[1] = '{32'h0, 16'd3, 16'd3,  1'b1};
    burst_out[2] = '{32'h0, 16'd2, 16'd10, 1'b0};
    burst_out[3] = '{32'h0, 16'd4, 16'd10, 1'b0};

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_id", out_id, 0);
    check("rst_out_iter", out_iter, 0);
    check("rst_out_escaped", out_escaped, 0);
    check("rst_mul_ld", mul_ld, 1);
    check("rst_mul_a0", mul_a0, 0);
    reset = 1'b0;
    @(negedge aclk);
    check("idle_in_ready", in_ready, 1);
    check("idle_mul_ld", mul_ld, 0);

    // Single points from the table
    for (int i = 0; i < 15; i++) begin
      max_iter = vecs[i].mi;
      send_point(vecs[i].cr, vecs[i].ci, 16'(100 + i));
      wait_result(rid, riter, resc);
      check($sformatf("vec%0d_id", i), rid, 64'(100 + i));
      check($sformatf("vec%0d_iter", i), riter, vecs[i].iter);
      check($sformatf("vec%0d_esc", i), resc, vecs[i].esc);
    end

    // Back-to-back burst filling every slot
    max_iter = 16'd10;
    repeat (2) @(negedge aclk);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_cr    = burst_in[k].cr;
      in_ci    = '0;
      in_id    = burst_in[k].id;
      check($sformatf("burst_ready%0d", k), in_ready, 1);
      @(negedge aclk);
    end
    in_valid = 1'b0;
    check("burst_full_ready", in_ready, 0);
    check("burst_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      wait_result(rid, riter, resc);
      check($sformatf("burst%0d_id", k), rid, burst_out[k].id);
      check($sformatf("burst%0d_iter", k), riter, burst_out[k].iter);
      check($sformatf("burst%0d_esc", k), resc, burst_out[k].esc);
    end

    // Output stalled with one result held and a second point escaping
    max_iter  = 16'd100;
    out_ready = 1'b0;
    send_point(32'h2000_0000, 32'h0, 16'd21);
    for (int n = 0; n < 200 && !out_valid; n++) @(negedge aclk);
    check("stall_first_valid", out_valid, 1);
    send_point(32'h1000_0000, 32'h0, 16'd22);
    flag = 1'b1;
    repeat (20) begin
      @(negedge aclk);
      if (!out_valid || out_id != 16'd21 || out_iter != 16'd2 || !out_escaped) flag = 1'b0;
    end
    check("stall_held_stable", flag, 1);
    check("stall_busy", busy, 1);
    out_ready = 1'b1;
    wait_result(rid, riter, resc);
    check("stall_r1_id", rid, 21);
    check("stall_r1_iter", riter, 2);
    wait_result(rid, riter, resc);
    check("stall_r2_id", rid, 22);
    check("stall_r2_iter", riter, 3);
    check("stall_r2_esc", resc, 1);

    // Reset with a non-escaping point in flight
    max_iter = 16'd1000;
    send_point(32'hF000_0000, 32'h0, 16'd31);
    repeat (6) @(negedge aclk);
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_mul_ld", mul_ld, 1);
    check("mid_rst_mul_a0", mul_a0, 0);
    @(negedge aclk);
    reset = 1'b0;
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_out_id", out_id, 0);
    check("post_rst_in_ready", in_ready, 1);
    flag = 1'b0;
    repeat (60) begin
      @(negedge aclk);
      if (out_valid || busy) flag = 1'b1;
    end
    check("post_rst_no_stale", flag, 0);

`ifdef MANDEL_STATS_EN
    reset = 1'b1;
    @(negedge aclk);
    reset = 1'b0;
    check("stat_rst_accepted", stat_accepted, 0);
    for (int i = 0; i < 5; i++) begin
      max_iter = vecs[i].mi;
      send_point(vecs[i].cr, vecs[i].ci, 16'(200 + i));
      wait_result(rid, riter, resc);
      check($sformatf("stat_vec%0d_iter", i), riter, vecs[i].iter);
    end
    check("stat_accepted", stat_accepted, 5);
    check("stat_retired", stat_retired, 5);
    check("stat_stall", stat_stall, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mandel_iter_sched.md
Name: mandel_iter_sched

Overview:
- Issue/recirculation scheduler for the pipelined escape-time datapath.
- Accepts points c = (cr, ci) and drives the clocked squaring multiplier stage (a·a, b·b, a·b plus c passthrough).
- Forms z' = z² + c on return and recirculates each point until it escapes or reaches max_iter.
- Retires (id, iteration count, escaped flag) on a valid/ready output.

Parameters:
- MUL_LAT, 1: cycles from mul_a/mul_b/mul_a0/mul_b0 to mul_aa/mul_bb/mul_ab/mul_a0r/mul_b0r; also the maximum number of points in flight.
- FRAC_BITS, 28: fractional bits of the signed 32-bit fixed-point format (Q4.28).
- ID_W, 16: point tag width.
- ITER_W, 16: iteration counter width.

Ports:
- aclk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  new point offered
- in_ready  out  1  point accepted this cycle when in_valid & in_ready
- in_cr, in_ci  in  32 each  c, Q4.28; valid range ±2.0
- in_id  in  ID_W  tag
- max_iter  in  ITER_W  iteration limit, sampled at each return
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_id  out  ID_W
- out_iter  out  ITER_W
- out_escaped  out  1
- busy  out  1  any point in flight or out_valid
- mul_ld  out  1  multiplier clear; equals reset
- mul_a, mul_b  out  32 each  z_re, z_im issued
- mul_a0, mul_b0  out  32 each  c issued alongside
- mul_aa, mul_bb, mul_ab, mul_a0r, mul_b0r  in  32 each  multiplier results and returned c

Behaviour:
- Reset: out_valid=0, busy=0, all sidecar valid bits=0, out_id/out_iter/out_escaped=0, mul_a/b/a0/b0=0. Reset mid-operation drops every in-flight point and any held result without emitting it.
- Sidecar: a shift register of depth MUL_LAT carries {valid, id, iter, z_re, z_im} in lockstep with the multiplier, so the return slot lines up with mul_aa/bb/ab/a0r/b0r.
- New point: issued with z=0, iter=0; mul_a0/mul_b0 = c. The input c is clamped per component to ±2.0 (0x2000_0000) on accept.
- Return handling, when the return slot is valid with z_k and iter=k:
  - esc = |z_re|>2.0 OR |z_im|>2.0 OR (mul_aa+mul_bb, evaluated 33-bit) > 4.0. The square sum is trusted only when both components are ≤2.0.
  - If esc: retire with iter=k, escaped=1.
  - Else if k ≥ max_iter: retire with iter=k, escaped=0.
  - Else reissue with z_re = mul_aa − mul_bb + mul_a0r, z_im = (mul_ab<<1) + mul_b0r, iter=k+1, c=(mul_a0r, mul_b0r). 32-bit wrap; overflow is impossible when not escaped.
- Retire blocked (out_valid & !out_ready): reissue unchanged z_k, c and iter=k. The point is retried next pass, with no iteration counted.
- Issue slot, one per cycle, priority order:
  - reissue of a returning point;
  - otherwise a new point if in_valid;
  - otherwise a bubble (valid=0).
- in_ready is combinational: high when the return slot is empty or retiring this cycle. Not gated by in_valid.
- Output register:
  - Loads on retire when !out_valid or out_ready (same-cycle pop and load allowed).
  - Holds stable while out_valid & !out_ready.
  - Retire order is not guaranteed; consumers use out_id.
- max_iter=0: first return retires with iter=0, escaped=0 (z0=0 never escapes).
- mul_ld = reset, so the multiplier registers zero during reset only.

Optional Feature:
- MANDEL_STATS_EN defined adds three outputs:
  - stat_accepted (32): points accepted.
  - stat_retired (32): points retired.
  - stat_stall (32): cycles with a retire blocked by a full output.
- All three are cleared by reset and wrap at 2³².
- Without the macro these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- mandel_pkg holds:
  - FRAC_BITS default;
  - FX_TWO = 32'h2000_0000;
  - FX_FOUR_SQ = 33'h0_4000_0000;
  - the sidecar entry typedef {valid, id, iter, z_re, z_im};
  - the clamp function.
- One sub-module, mandel_escape_check (combinational): takes z_re, z_im, aa, bb, iter, max_iter and returns retire, escaped.

Test Plan:
- c=(2.0,0), max_iter=100 → out_iter=2, out_escaped=1 (z: 0, 2, 6).
- c=(1.0,0) → out_iter=3, escaped=1. c=(0,0), max_iter=50 → out_iter=50, escaped=0.
- MUL_LAT=4:
  - Stimulus: ids 1–4 back-to-back, c = (2,0), (0,0), (1,0), (-2,0); max_iter=10.
  - Response: in_ready low while all slots recirculate; results id1 iter2 esc1, id3 iter3 esc1, id2 iter10 esc0, id4 iter10 esc0 (−2 stays at 2).
- Hold out_ready=0 for 20 cycles with one result pending and a second point escaping → first result stable; second point retries with out_iter unchanged and appears after out_ready rises.
- Point in flight, then assert reset for one cycle → out_valid=0, busy=0, mul_ld=1 that cycle; no stale result afterwards.
- in_cr=0x7000_0000 clamps to 2.0 → out_iter=2. With MANDEL_STATS_EN: 5 points accepted → stat_accepted=5, stat_retired=5.
